// File: rtl/led_defs_pkg.sv
// Shared constants and helpers for the multiplexed LED scan controller.
package led_defs;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int BCD_MAX    = 9;
  localparam int SLOT_W     = $clog2(NUM_DIGITS);
  localparam int PWM_W      = 4;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(BCD_MAX);
  endfunction
endpackage

// File: rtl/led_scan_ctrl_slot_timer.sv
// Slot timing: per-slot cycle counter, slot index and BLANK/DRIVE phase.
module slot_timer
  import led_defs::*;
#(
  parameter int SLOT_CYCLES  = 12000,
  parameter int BLANK_CYCLES = 12
) (
  input  logic              hwclk,
  input  logic              rst,
  output logic [SLOT_W-1:0] slot,
  output logic              drive,
  output logic              drive_enter,
  output logic              drive_first,
  output logic              frame_end
);
  localparam int               CNT_W     = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  phase_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              slot_last;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q <= PH_BLANK;
      cnt_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

  // Slot index is exactly SLOT_W bits wide, so 3 -> 0 wraps naturally.
  always_comb begin
    slot_last = (cnt_q == CNT_LAST);
    cnt_d     = slot_last ? '0 : cnt_q + 1'b1;
    slot_d    = slot_last ? slot_q + 1'b1 : slot_q;
    state_d   = state_q;
    case (state_q)
      PH_BLANK: if (cnt_d == CNT_BLANK) state_d = PH_DRIVE;
      PH_DRIVE: if (slot_last) state_d = PH_BLANK;
    endcase
    drive       = (state_q == PH_DRIVE);
    drive_enter = (state_q == PH_BLANK) && (state_d == PH_DRIVE);
    drive_first = drive && (cnt_q == CNT_BLANK);
    frame_end   = slot_last && (slot_q == SLOT_W'(NUM_DIGITS - 1));
    slot        = slot_q;
  end
endmodule

// File: rtl/led_scan_ctrl.sv
// Four-digit multiplexed LED scanner with PWM dimming and frame-aligned
// double-buffered digit updates.
module led_scan_ctrl
  import led_defs::*;
#(
  parameter int SLOT_CYCLES  = 12000,
  parameter int BLANK_CYCLES = 12
) (
  input  logic                          hwclk,
  input  logic                          rst,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  input  logic                          load,
  input  logic [PWM_W-1:0]              brightness,
  output logic [DIGIT_W-1:0]            led,
  output logic [NUM_DIGITS-1:0]         sel,
  output logic                          load_ack,
  output logic                          frame_done,
  output logic                          bcd_err
);
  logic [SLOT_W-1:0]             slot;
  logic                          drive, drive_enter, drive_first, frame_end;
  logic [NUM_DIGITS*DIGIT_W-1:0] active_q, pend_q;
  logic                          pend_vld_q;
  logic [PWM_W-1:0]              bright_q, pwm_q;
  logic [DIGIT_W-1:0]            digit_cur;
  logic [NUM_DIGITS-1:0]         sel_hot;
  logic                          digit_ok, lit;

  slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .hwclk      (hwclk),
    .rst        (rst),
    .slot       (slot),
    .drive      (drive),
    .drive_enter(drive_enter),
    .drive_first(drive_first),
    .frame_end  (frame_end)
  );

  always_comb begin
    digit_cur     = active_q[int'(slot)*DIGIT_W +: DIGIT_W];
    sel_hot       = '0;
    sel_hot[slot] = 1'b1;
    digit_ok      = is_bcd(digit_cur);
    lit           = drive && digit_ok && (pwm_q < bright_q);
  end

  // Data-only capture: pending value is qualified by pend_vld_q, brightness by drive.
  always_ff @(posedge hwclk) begin
    if (load) pend_q <= digits;
    if (drive_enter) bright_q <= brightness;
  end

  // Registered frame_done marks slot 0 cycle 0 (still BLANK), so swapping
  // active there can never tear a visible frame.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      active_q   <= '0;
      pend_vld_q <= 1'b0;
      pwm_q      <= '0;
      led        <= '0;
      sel        <= '0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      if (frame_done && pend_vld_q) active_q <= pend_q;
      pend_vld_q <= load || (pend_vld_q && !frame_done);
      load_ack   <= frame_done && pend_vld_q;
      pwm_q      <= drive_enter ? '0 : pwm_q + 1'b1;
      led        <= lit ? digit_cur : '0;
      sel        <= drive ? sel_hot : '0;
      frame_done <= frame_end;
      bcd_err    <= drive_first && !digit_ok;
    end
  end
endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter SLOT_CYCLES, default 12000, meaning hwclk cycles per digit slot (1 kHz at 12 MHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 12, meaning cycles at the start of each slot with all outputs off (anti-ghosting).
REQ-003 SHALL have port hwclk  input  1  system clock, 12 MHz.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port digits  input  16  four BCD digits, digit k at bits [4k+3:4k].
REQ-006 SHALL have port load  input  1  single-cycle strobe: request to display digits.
REQ-007 SHALL have port brightness  input  4  PWM duty level, 0 = off, 15 = max.
REQ-008 SHALL have port led  output  4  shared LED data bus (active-high).
REQ-009 SHALL have port sel  output  4  one-hot digit select, bit k enables digit k.
REQ-010 SHALL have port load_ack  output  1  one-cycle pulse when pending digits become active.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on the last cycle of slot 3.
REQ-012 SHALL have port bcd_err  output  1  one-cycle pulse when a digit >9 enters a DRIVE phase.

Function
REQ-013 SHALL scan slots 0,1,2,3,0,... each exactly SLOT_CYCLES long; slot counter wraps 3->0.
REQ-014 SHALL have two states per slot: BLANK (first BLANK_CYCLES cycles), then DRIVE (remaining SLOT_CYCLES-BLANK_CYCLES cycles).
REQ-015 In BLANK, sel and led SHALL be 4'b0000.
REQ-016 In DRIVE, sel SHALL be one-hot for the current slot; led SHALL be the active digit for that slot, gated by PWM.
REQ-017 PWM: a 4-bit counter SHALL reset to 0 on entry to DRIVE and free-run; led SHALL be driven only when pwm_cnt < brightness, else 0; sel stays asserted.
REQ-018 brightness SHALL be sampled once on DRIVE entry and held constant for that slot.
REQ-019 A digit value 10..15 SHALL drive led = 0 for the whole slot and pulse bcd_err on the first DRIVE cycle.
REQ-020 On load, digits SHALL be captured into a pending register and a pending flag SHALL be set.
REQ-021 A second load while pending SHALL overwrite the pending value; the latest load wins, and no extra load_ack is issued.
REQ-022 At the frame boundary (the cycle frame_done is high), if pending is set, active SHALL take the pending value on the next edge, pending SHALL clear, and load_ack SHALL pulse in that same next cycle.
REQ-023 A load coincident with frame_done SHALL be captured into pending and applied at the following frame boundary, never torn mid-frame.
REQ-024 Active digits SHALL NOT change during a frame.
REQ-025 Outputs SHALL be registered, with 1-cycle latency from internal state to pins.

Reset
REQ-026 While rst is high: led=0, sel=0, load_ack=0, frame_done=0, bcd_err=0; slot=0, state=BLANK, cycle counter=0, pwm_cnt=0, active=16'h0000, pending cleared.
REQ-027 Reset asserted mid-slot or mid-frame SHALL abandon the frame; the first cycle after release is cycle 0 of slot 0 BLANK.
REQ-028 A load coincident with rst SHALL be ignored.

Structure
REQ-029 A shared package/header led_defs SHALL hold the digit count (4), the digit width (4) and the BCD maximum (9).
REQ-030 The slot/cycle timing SHALL be a sub-module, slot_timer (cycle counter plus slot index, emitting blank/drive/frame_end).
REQ-031 The PWM, shadow registers and output registers SHALL reside in led_scan_ctrl.

Verification
(Simulation uses SLOT_CYCLES=40, BLANK_CYCLES=4.)
REQ-032 Reset release, digits=16'h4321 loaded, brightness=15 -> after one frame, slot k drives led=k+1 with sel=1<<k; sel=0 during 4 BLANK cycles; frame_done pulses every 160 cycles.
REQ-033 brightness=4 -> within each DRIVE, led is on for exactly 4 of every 16 cycles; brightness=0 -> led is always 0 while sel still steps.
REQ-034 load 16'h1111 then load 16'h2222 mid-frame -> one load_ack, 1 cycle after frame_done; the next frame shows 2,2,2,2; the current frame is unchanged.
REQ-035 digits=16'h00A0 -> slot 1 led=0 for the whole slot, bcd_err pulses once per frame at slot 1 cycle 4.
REQ-036 rst at slot 2 cycle 20 for 3 cycles -> outputs are 0 during reset; after release, slot 0 BLANK, active=0, a pending load is lost (no load_ack).
